// File: rtl/mux_256x1_reg_pkg.sv
// Package: mux_pkg
//   Shared sizing constants for the registered 256:1 bit-select block.
//   N_IN   : number of single-bit data inputs (2**SEL_W)
//   SEL_W  : select width
//   GRP_W  : select bits consumed by each 16:1 leaf mux
//   GRP_N  : inputs per leaf mux
//   N_GRP  : number of leaf muxes in the first tree level
package mux_pkg;
   localparam int N_IN  = 256;
   localparam int SEL_W = 8;
   localparam int GRP_W = 4;
   localparam int GRP_N = 1 << GRP_W;
   localparam int N_GRP = N_IN / GRP_N;
endpackage

// File: rtl/mux_256x1_reg_if.sv
// Interface: mux_256x1_reg_if
//   Bundles the select/data inputs and the registered output.
//   sel   : index of the bit to forward
//   a_in  : data vector, bit i is input i
//   out   : registered selected bit
//   master: drives sel/a_in, observes out
//   slave : the mux block itself
interface mux_256x1_reg_if;
   import mux_pkg::*;
   logic [SEL_W-1:0] sel;
   logic [N_IN-1:0]  a_in;
   logic             out;

   modport master (output sel, output a_in, input  out);
   modport slave  (input  sel, input  a_in, output out);
endinterface

// File: rtl/mux_256x1_reg_mux16.sv
// Module: mux_16x1
//   Purely combinational 16:1 single-bit multiplexer, leaf of the select tree.
//   d : 16 data bits
//   s : 4-bit select
//   y : d[s]
module mux_16x1
   import mux_pkg::*;
(
   input  logic [GRP_N-1:0] d,
   input  logic [GRP_W-1:0] s,
   output logic             y
);
   assign y = d[s];
endmodule

// File: rtl/mux_256x1_reg.sv
// Module: mux_256x1_reg
//   Registered 256:1 bit select. Two-level tree of 16:1 muxes feeding a
//   single async-reset flop, so out = a_in[sel] one cycle after sampling.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, forces out to 0
//   bus   : slave side of mux_256x1_reg_if (sel, a_in in; out out)
module mux_256x1_reg
   import mux_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   mux_256x1_reg_if.slave     bus
);
   logic [N_GRP-1:0] grp_y;
   logic             sel_bit;

   // First level: each leaf picks one bit of its 16-bit slice with sel[3:0].
   for (genvar g = 0; g < N_GRP; g++) begin : g_leaf
      mux_16x1 u_leaf (
         .d (bus.a_in[g*GRP_N +: GRP_N]),
         .s (bus.sel[GRP_W-1:0]),
         .y (grp_y[g])
      );
   end

   // Second level: sel[7:4] chooses which slice result to keep.
   mux_16x1 u_root (
      .d (grp_y),
      .s (bus.sel[SEL_W-1:GRP_W]),
      .y (sel_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.out <= 1'b0;
      else        bus.out <= sel_bit;
   end
endmodule

// File: tb/tb_mux_256x1_reg.sv
module tb_mux_256x1_reg;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mux_256x1_reg_if bus_if ();

   mux_256x1_reg dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: bit sel of a vector, by shifting the whole vector down.
   function automatic logic ref_bit(input logic [255:0] a, input int s);
      logic [255:0] t;
      t = a >> s;
      return t[0];
   endfunction

   function automatic logic [255:0] rand_vec();
      logic [255:0] v;
      for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bus_if.a_in = '1;
      bus_if.sel = 8'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (bus_if.out !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d out=%b exp=0", k, bus_if.out);
         end
      end
      // Release: first capture on the next rising edge.
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus_if.out !== 1'b1) begin
         bad++;
         $display("FAIL reset_release out=%b exp=1", bus_if.out);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus_if.a_in = '1;
      bus_if.sel = 8'd5;
      @(posedge clk);
      #2;
      total++;
      if (bus_if.out !== 1'b1) begin
         bad++;
         $display("FAIL async_pre out=%b exp=1", bus_if.out);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (bus_if.out !== 1'b0) begin
         bad++;
         $display("FAIL async_assert out=%b exp=0", bus_if.out);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus_if.out !== 1'b0) begin
         bad++;
         $display("FAIL async_hold out=%b exp=0", bus_if.out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus_if.out !== 1'b1) begin
         bad++;
         $display("FAIL async_release out=%b exp=1", bus_if.out);
      end
   endtask

   task automatic test_pattern();
      int exp_list[8] = '{1, 1, 0, 0, 0, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus_if.a_in = 256'hA3;
         bus_if.sel = 8'(i);
         @(negedge clk);
         total++;
         if (bus_if.out !== exp_list[i][0]) begin
            bad++;
            $display("FAIL pattern sel=%0d out=%b exp=%0d", i, bus_if.out, exp_list[i]);
         end
      end
   endtask

   task automatic test_upper_zero();
      int sels[6] = '{8, 9, 10, 12, 13, 15};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus_if.a_in = 256'hA3;
         bus_if.sel = 8'(sels[i]);
         @(negedge clk);
         total++;
         if (bus_if.out !== 1'b0) begin
            bad++;
            $display("FAIL upper_zero sel=%0d out=%b exp=0", sels[i], bus_if.out);
         end
      end
   endtask

   task automatic test_extremes();
      logic [255:0] av[4];
      int           sv[4] = '{255, 254, 0, 255};
      logic         ev[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      av[0] = 256'd1 << 255;
      av[1] = 256'd1 << 255;
      av[2] = 256'd1;
      av[3] = 256'd1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus_if.a_in = av[i];
         bus_if.sel = 8'(sv[i]);
         @(negedge clk);
         total++;
         if (bus_if.out !== ev[i]) begin
            bad++;
            $display("FAIL extreme%0d sel=%0d out=%b exp=%b", i, sv[i], bus_if.out, ev[i]);
         end
      end
   endtask

   task automatic test_walking_one();
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         bus_if.a_in = 256'd1 << i;
         bus_if.sel = 8'(i);
         @(negedge clk);
         total++;
         if (bus_if.out !== 1'b1) begin
            bad++;
            $display("FAIL walk_hit i=%0d out=%b exp=1", i, bus_if.out);
         end
         bus_if.sel = 8'(i ^ 1);
         @(negedge clk);
         total++;
         if (bus_if.out !== 1'b0) begin
            bad++;
            $display("FAIL walk_miss i=%0d sel=%0d out=%b exp=0", i, i ^ 1, bus_if.out);
         end
      end
   endtask

   // Back-to-back: new sel/a_in every cycle, scoreboard holds the bit due next cycle.
   task automatic test_back_to_back();
      logic q[$];
      logic [255:0] a;
      int           s;
      logic         e;
      for (int n = 0; n <= 300; n++) begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (bus_if.out !== e) begin
               bad++;
               $display("FAIL b2b n=%0d out=%b exp=%b", n, bus_if.out, e);
            end
         end
         if (n < 300) begin
            a = rand_vec();
            s = $urandom_range(0, 255);
            bus_if.a_in = a;
            bus_if.sel = 8'(s);
            q.push_back(ref_bit(a, s));
         end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_async_reset();
      test_pattern();
      test_upper_zero();
      test_extremes();
      test_walking_one();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
